bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
- Four-master round-robin bus arbiter with an access-timeout watchdog.
- Grants shared-bus ownership to one master at a time and holds the grant for a whole access.
- Watches the muxed slave ready (m_rdy_, from the slave-side read mux) and aborts any access that stalls too long.
- Sits between the master request lines and the master-side address/control mux; its owner output drives that mux select.

Parameters:
TIMEOUT, 200, cycles an access may wait for m_rdy_ before abort (2..2^TMO_W-1)
TMO_W, 8, width of the watchdog counter

Ports:
clk  in  1  system clock
reset_  in  1  asynchronous active-low reset
m0_req_  in  1  master 0 bus request, active low
m1_req_  in  1  master 1 bus request, active low
m2_req_  in  1  master 2 bus request, active low
m3_req_  in  1  master 3 bus request, active low
m0_grnt_  out  1  master 0 grant, active low, registered
m1_grnt_  out  1  master 1 grant, active low, registered
m2_grnt_  out  1  master 2 grant, active low, registered
m3_grnt_  out  1  master 3 grant, active low, registered
owner  out  2  index of current/last granted master (mux select), registered
bus_as_  in  1  address strobe of the granted master (already muxed), active low
m_rdy_  in  1  muxed slave ready, active low
bus_busy  out  1  high while any grant is asserted
bus_tmo  out  1  one-cycle pulse on access abort, active high

Behaviour:
- Reset: asynchronous on negedge reset_.
  - All grnt_ = 1 (disabled), owner = 2'd3, bus_busy = 0, bus_tmo = 0, counter = 0, state = IDLE.
  - Reset mid-access drops the grant immediately; no tmo pulse.
- States: IDLE, OWNED, ACCESS, ABORT. All outputs are registered.
- Round-robin search order: owner+1, owner+2, owner+3, owner (mod 4). After reset, m0 wins first.
- IDLE:
  - If any req_ is low, grant the first requester in search order at the next edge: grnt_ low, owner updated, bus_busy = 1, go to OWNED.
  - Latency from req_ low to grnt_ low is 1 cycle.
- OWNED:
  - bus_as_ low -> ACCESS, counter cleared.
  - Otherwise, if the owner's req_ is high, release:
    - If another master requests, re-grant to it at the same edge (no idle cycle), stay in OWNED.
    - Otherwise, drop all grants and go to IDLE; owner keeps its last value.
  - If bus_as_ is low in the same cycle req_ goes high, ACCESS takes priority.
- ACCESS:
  - Grant is never revoked; the owner's req_ is ignored until the access ends.
  - m_rdy_ low -> access complete:
    - Owner req_ still low -> OWNED.
    - Owner req_ high -> release exactly as in OWNED.
  - Otherwise counter increments by 1 per cycle.
  - If counter == TIMEOUT-1 and m_rdy_ is high -> ABORT.
  - m_rdy_ arriving in the same cycle the counter hits TIMEOUT-1 counts as success (no abort).
- ABORT (1 cycle):
  - bus_tmo = 1 for exactly this cycle; grant is held.
  - Next state: OWNED if owner req_ is low, else release as in OWNED.
  - Master must deassert bus_as_. If bus_as_ is still low on the cycle after ABORT, a new ACCESS starts with a fresh count.
- Counter:
  - Saturates, never wraps; cleared on entry to ACCESS.
  - Only meaningful in ACCESS.
- Grant encoding: at most one grnt_ is low at any time (one-hot-low or all high). bus_busy equals the NOR-sense of all grants.
- Non-owner req_ changes never affect the current grant.

Test Plan:
- Reset release, m2_req_ low at cycle 0 -> m2_grnt_ low and owner=2 at cycle 1; other grants high; bus_busy=1.
- All four req_ low continuously, each owner releases after one OWNED cycle -> grant order m0,m1,m2,m3,m0 with no gap cycles between grants.
- m1 owns, bus_as_ low, m_rdy_ low after 5 cycles while m1_req_ high -> grant held through ACCESS; m1_grnt_ high on the edge after m_rdy_; next requester granted same edge.
- TIMEOUT=4, m_rdy_ held high after bus_as_ -> bus_tmo pulses exactly 1 cycle, 4 cycles after ACCESS entry; grant kept; back to OWNED.
- TIMEOUT=4, m_rdy_ low exactly when counter=3 -> no bus_tmo; normal completion.
- reset_ pulsed low mid-ACCESS (asynchronous, between edges) -> all grnt_ high immediately; owner=3, bus_tmo=0; state IDLE after release.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter. Holds a grant for a whole access and
// aborts accesses whose muxed slave ready stays high for TIMEOUT cycles.
module bus_rr_arbiter #(
    parameter int TIMEOUT = 200,
    parameter int TMO_W   = 8
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    input  logic       bus_as_,
    input  logic       m_rdy_,
    output logic       bus_busy,
    output logic       bus_tmo
);

    typedef enum logic [1:0] {IDLE, OWNED, ACCESS, ABORT} state_t;

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [3:0]       gnt_n_q, gnt_n_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    logic [3:0] req;
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic       release_own;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    // First requester after the current owner, wrapping round to the owner last.
    always_comb begin
        logic [1:0] idx;
        pick_vld = 1'b0;
        pick_idx = owner_q;
        for (int i = 1; i <= 4; i++) begin
            idx = owner_q + 2'(i);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_n_d     = gnt_n_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        tmo_d       = 1'b0;
        cnt_d       = cnt_q;
        release_own = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWNED;
                    owner_d = pick_idx;
                    gnt_n_d = ~(4'b0001 << pick_idx);
                    busy_d  = 1'b1;
                end
            end
            OWNED: begin
                if (!bus_as_) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else if (!req[owner_q]) begin
                    release_own = 1'b1;
                end
            end
            ACCESS: begin
                if (!m_rdy_) begin
                    if (req[owner_q]) state_d = OWNED;
                    else              release_own = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                    tmo_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                if (req[owner_q]) state_d = OWNED;
                else              release_own = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Owner has dropped its request, so the pick can only land on another master.
        if (release_own) begin
            if (pick_vld) begin
                state_d = OWNED;
                owner_d = pick_idx;
                gnt_n_d = ~(4'b0001 << pick_idx);
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                gnt_n_d = 4'hF;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            gnt_n_q <= 4'hF;
            owner_q <= 2'd3;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_n_q <= gnt_n_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = gnt_n_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign bus_tmo  = tmo_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter with TIMEOUT=4; expected grant vectors are queued
// as stimulus is applied and popped after each clock edge.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] req_n = 4'hF;
    logic       bus_as_ = 1'b1;
    logic       m_rdy_ = 1'b1;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       bus_busy, bus_tmo;
    logic [3:0] gnt_n;
    logic [3:0] exp_q[$];
    logic [3:0] e;
    int         errors = 0;
    int         checks = 0;

    assign gnt_n = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    always #5 clk = ~clk;

    bus_rr_arbiter #(.TIMEOUT(4), .TMO_W(8)) dut (
        .clk(clk), .reset_(reset_),
        .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
        .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
        .owner(owner), .bus_as_(bus_as_), .m_rdy_(m_rdy_),
        .bus_busy(bus_busy), .bus_tmo(bus_tmo)
    );

    function automatic logic [3:0] g_n(input int i);
        logic [3:0] one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        req_n = 4'hF; bus_as_ = 1'b1; m_rdy_ = 1'b1;
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        reset_ = 1'b0;
        #2;
        checks++; if (gnt_n !== 4'hF) begin errors++; $display("FAIL reset_gnt gnt_n=%b exp=1111", gnt_n); end
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner owner=%0d exp=3", owner); end
        checks++; if (bus_busy !== 1'b0 || bus_tmo !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b tmo=%b exp=0 0", bus_busy, bus_tmo); end
        reset_ = 1'b1;
    endtask

    task automatic test_first_grant;
        req_n = 4'b1011;
        exp_q.push_back(g_n(2));
        step();
        e = exp_q.pop_front();
        checks++; if (gnt_n !== e) begin errors++; $display("FAIL first_gnt gnt_n=%b exp=%b", gnt_n, e); end
        checks++; if (owner !== 2'd2 || bus_busy !== 1'b1) begin errors++; $display("FAIL first_owner owner=%0d busy=%b exp=2 1", owner, bus_busy); end
        req_n = 4'hF;
        exp_q.push_back(4'hF);
        step();
        e = exp_q.pop_front();
        checks++; if (gnt_n !== e || bus_busy !== 1'b0 || owner !== 2'd2) begin
            errors++; $display("FAIL first_release gnt_n=%b busy=%b owner=%0d exp=%b 0 2", gnt_n, bus_busy, owner, e);
        end
    endtask

    task automatic test_rotation;
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_n = 4'h0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(g_n(order[k]));
            step();
            e = exp_q.pop_front();
            checks++; if (gnt_n !== e || owner !== 2'(order[k]) || bus_busy !== 1'b1) begin
                errors++; $display("FAIL rotation[%0d] gnt_n=%b owner=%0d busy=%b exp=%b %0d 1", k, gnt_n, owner, bus_busy, e, order[k]);
            end
            req_n = 4'h0;
            req_n[order[k]] = 1'b1;
        end
        req_n = 4'hF;
        exp_q.push_back(4'hF);
        step();
        e = exp_q.pop_front();
        checks++; if (gnt_n !== e || owner !== 2'd0) begin errors++; $display("FAIL rotation_idle gnt_n=%b owner=%0d exp=%b 0", gnt_n, owner, e); end
    endtask

    task automatic test_access_release;
        req_n = 4'b1101;
        step();
        checks++; if (gnt_n !== g_n(1)) begin errors++; $display("FAIL acc_grant gnt_n=%b exp=%b", gnt_n, g_n(1)); end
        // m1 drops its request in the same cycle as the strobe; the access wins
        bus_as_ = 1'b0;
        req_n = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(g_n(1));
            step();
            bus_as_ = 1'b1;
            e = exp_q.pop_front();
            checks++; if (gnt_n !== e || bus_tmo !== 1'b0) begin errors++; $display("FAIL acc_hold[%0d] gnt_n=%b tmo=%b exp=%b 0", k, gnt_n, bus_tmo, e); end
        end
        m_rdy_ = 1'b0;
        exp_q.push_back(g_n(3));
        step();
        m_rdy_ = 1'b1;
        e = exp_q.pop_front();
        checks++; if (gnt_n !== e || owner !== 2'd3 || bus_busy !== 1'b1) begin
            errors++; $display("FAIL acc_handoff gnt_n=%b owner=%0d busy=%b exp=%b 3 1", gnt_n, owner, bus_busy, e);
        end
        req_n = 4'hF;
        step();
        checks++; if (gnt_n !== 4'hF) begin errors++; $display("FAIL acc_idle gnt_n=%b exp=1111", gnt_n); end
    endtask

    task automatic test_timeout;
        req_n = 4'b1011;
        step();
        bus_as_ = 1'b0;
        step();
        bus_as_ = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(g_n(2));
            step();
            e = exp_q.pop_front();
            checks++; if (bus_tmo !== (k == 4) || gnt_n !== e) begin
                errors++; $display("FAIL tmo_cycle[%0d] tmo=%b gnt_n=%b exp=%b %b", k, bus_tmo, gnt_n, (k == 4), e);
            end
        end
        // ABORT followed by a fresh strobe starts a new access with a full count
        bus_as_ = 1'b0;
        step();
        bus_as_ = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (bus_tmo !== (k == 4)) begin errors++; $display("FAIL tmo_again[%0d] tmo=%b exp=%b", k, bus_tmo, (k == 4)); end
        end
        req_n = 4'hF;
        step();
        checks++; if (gnt_n !== 4'hF || bus_busy !== 1'b0) begin errors++; $display("FAIL tmo_release gnt_n=%b busy=%b exp=1111 0", gnt_n, bus_busy); end
    endtask

    task automatic test_boundary;
        req_n = 4'b1011;
        step();
        bus_as_ = 1'b0;
        step();
        bus_as_ = 1'b1;
        for (int k = 0; k < 3; k++) step();
        m_rdy_ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(g_n(2));
            step();
            m_rdy_ = 1'b1;
            e = exp_q.pop_front();
            checks++; if (bus_tmo !== 1'b0 || gnt_n !== e) begin
                errors++; $display("FAIL boundary[%0d] tmo=%b gnt_n=%b exp=0 %b", k, bus_tmo, gnt_n, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        bus_as_ = 1'b0;
        step();
        bus_as_ = 1'b1;
        step();
        #2;
        reset_ = 1'b0;
        #1;
        checks++; if (gnt_n !== 4'hF || owner !== 2'd3) begin errors++; $display("FAIL rst_mid gnt_n=%b owner=%0d exp=1111 3", gnt_n, owner); end
        checks++; if (bus_tmo !== 1'b0 || bus_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_flags tmo=%b busy=%b exp=0 0", bus_tmo, bus_busy); end
        req_n = 4'hF;
        step();
        reset_ = 1'b1;
        step();
        step();
        checks++; if (gnt_n !== 4'hF || bus_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle gnt_n=%b busy=%b exp=1111 0", gnt_n, bus_busy); end
        req_n = 4'b0101;
        step();
        checks++; if (gnt_n !== g_n(1) || owner !== 2'd1) begin errors++; $display("FAIL rst_mid_rr gnt_n=%b owner=%0d exp=%b 1", gnt_n, owner, g_n(1)); end
        req_n = 4'hF;
        step();
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_access_release();
        test_timeout();
        test_boundary();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left size=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
